multicycle_control_fsm: RTL

//  Control sequencer for the multi-cycle RV32I CPU. It shares one memory port and one ALU across instruction phases.

---
 rtl/cpu_ctrl_pkg.sv | 52 +++++
 rtl/ctrl_output_decode.sv | 78 +++++++
 rtl/multicycle_control_fsm.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control sequencer:
// opcodes, FSM states and datapath mux codes.
package cpu_ctrl_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_ITYPE  = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_ECALL  = 7'h73;

    typedef enum logic [3:0] {
        S_IF, S_ID, S_EX_R, S_EX_I, S_EX_ADDR, S_EX_BR, S_EX_JAL, S_EX_JALR,
        S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_HALT
    } state_t;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_TARGET = 2'd1;
    localparam logic [1:0] PC_SRC_JALR   = 2'd2;

    localparam logic [1:0] WB_ALU_OUT = 2'd0;
    localparam logic [1:0] WB_MDR     = 2'd1;
    localparam logic [1:0] WB_PC4     = 2'd2;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_FUNCT  = 2'd1;
    localparam logic [1:0] ALU_BRANCH = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_class;
        logic       inst_retired;
    } ctrl_t;

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational map from FSM state (plus bcond for branches) to the raw control word.
// Handshake gating and reset masking are applied by the parent.
module ctrl_output_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   bcond,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            S_IF: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
            end
            S_ID: ctrl.alu_src_b = SRC_B_IMM;
            S_EX_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_RS2;
                ctrl.alu_class = ALU_FUNCT;
            end
            S_EX_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_class = ALU_FUNCT;
            end
            S_EX_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
            end
            S_EX_BR: begin
                ctrl.alu_src_a    = 1'b1;
                ctrl.alu_src_b    = SRC_B_RS2;
                ctrl.alu_class    = ALU_BRANCH;
                ctrl.pc_write     = 1'b1;
                ctrl.pc_src       = bcond ? PC_SRC_TARGET : PC_SRC_PLUS4;
                ctrl.inst_retired = 1'b1;
            end
            S_EX_JAL: begin
                ctrl.reg_write    = 1'b1;
                ctrl.wb_sel       = WB_PC4;
                ctrl.pc_write     = 1'b1;
                ctrl.pc_src       = PC_SRC_TARGET;
                ctrl.inst_retired = 1'b1;
            end
            S_EX_JALR: begin
                ctrl.alu_src_a    = 1'b1;
                ctrl.alu_src_b    = SRC_B_IMM;
                ctrl.reg_write    = 1'b1;
                ctrl.wb_sel       = WB_PC4;
                ctrl.pc_write     = 1'b1;
                ctrl.pc_src       = PC_SRC_JALR;
                ctrl.inst_retired = 1'b1;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write    = 1'b1;
                ctrl.i_or_d       = 1'b1;
                ctrl.pc_write     = 1'b1;
                ctrl.inst_retired = 1'b1;
            end
            S_WB_ALU, S_WB_MEM: begin
                ctrl.reg_write    = 1'b1;
                ctrl.wb_sel       = (state == S_WB_MEM) ? WB_MDR : WB_ALU_OUT;
                ctrl.pc_write     = 1'b1;
                ctrl.inst_retired = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: state register, next-state logic,
// memory-wait watchdog and sticky halt flags.
module multicycle_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       halt_cond,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_class,
    output logic       inst_retired,
    output logic       is_halted,
    output logic       mem_timeout
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT) + 1;

    state_t          state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            is_halted_q, mem_timeout_q;
    logic            waiting, timeout, ecall_nop, ready_gate;
    ctrl_t           ctrl;

    assign waiting   = (state_q == S_IF) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timeout   = waiting && !mem_ready && (wait_cnt_q == CntW'(MEM_TIMEOUT - 1));
    assign ecall_nop = (state_q == S_ID) && (opcode == OP_ECALL) && !halt_cond;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IF: begin
                if (timeout)        state_d = S_HALT;
                else if (mem_ready) state_d = S_ID;
            end
            S_ID: begin
                case (opcode)
                    OP_RTYPE:                   state_d = S_EX_R;
                    OP_ITYPE, OP_LUI, OP_AUIPC: state_d = S_EX_I;
                    OP_LOAD, OP_STORE:          state_d = S_EX_ADDR;
                    OP_BRANCH:                  state_d = S_EX_BR;
                    OP_JAL:                     state_d = S_EX_JAL;
                    OP_JALR:                    state_d = S_EX_JALR;
                    OP_ECALL:                   state_d = halt_cond ? S_HALT : S_IF;
                    default:                    state_d = S_HALT;
                endcase
            end
            S_EX_R, S_EX_I:                 state_d = S_WB_ALU;
            S_EX_ADDR:                      state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_EX_BR, S_EX_JAL, S_EX_JALR:   state_d = S_IF;
            S_MEM_RD: begin
                if (timeout)        state_d = S_HALT;
                else if (mem_ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                if (timeout)        state_d = S_HALT;
                else if (mem_ready) state_d = S_IF;
            end
            S_WB_ALU, S_WB_MEM:             state_d = S_IF;
            default:                        state_d = S_HALT;
        endcase
    end

    // Counts consecutive stalled cycles; any state change or completion restarts it.
    assign wait_cnt_d = (waiting && !mem_ready && (state_d == state_q)) ?
                        wait_cnt_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IF;
            wait_cnt_q    <= '0;
            is_halted_q   <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (state_d == S_HALT) is_halted_q   <= 1'b1;
            if (timeout)           mem_timeout_q <= 1'b1;
        end
    end

    ctrl_output_decode u_decode (
        .state (state_q),
        .bcond (bcond),
        .ctrl  (ctrl)
    );

    // Completion strobes in IF and MEM_WR only fire on the cycle memory responds.
    assign ready_gate = ((state_q == S_IF) || (state_q == S_MEM_WR)) ? mem_ready : 1'b1;

    // Strobes are masked by the raw reset so an async abort kills them immediately.
    assign pc_write     = reset & ((ctrl.pc_write & ready_gate) | ecall_nop);
    assign inst_retired = reset & ((ctrl.inst_retired & ready_gate) | ecall_nop);
    assign ir_write     = reset & ctrl.ir_write & ready_gate;
    assign mem_read     = reset & ctrl.mem_read & !timeout;
    assign mem_write    = reset & ctrl.mem_write & !timeout;
    assign reg_write    = reset & ctrl.reg_write;
    assign pc_src       = ctrl.pc_src;
    assign i_or_d       = ctrl.i_or_d;
    assign wb_sel       = ctrl.wb_sel;
    assign alu_src_a    = ctrl.alu_src_a;
    assign alu_src_b    = ctrl.alu_src_b;
    assign alu_class    = ctrl.alu_class;
    assign is_halted    = is_halted_q;
    assign mem_timeout  = mem_timeout_q;

endmodule
